cmd_controller: RTL and testbench
=================================

// Module: cmd_controller
// PURPOSE
//  Sequences decoded SPI frames (command, databyte1, databyte2) into game
//  registers (state, score) and the tile memory. Owns the single-port tile
//  memory address/write lines: VGA read port (re/raddr) always wins; queued
//  writes and CLEAR sweeps proceed only on cycles with re low.
//  Sits in top between spi and vga_top/tile RAM.
// PARAMETERS
//  ADDR_W     10    tile memory address width
//  DATA_W     3     tile data width (R,G,B)
//  STATE_W    16    game state register width
//  SCORE_MAX  999   saturation value for score (10-bit)
// PORTS
//  clk        in   1        system clock, single clock domain
//  resetB     in   1        asynchronous, active-low reset
//  cs         in   1        raw SPI chip select (async); high = idle
//  command    in   8        [7:4] opcode, [3:0] operand; stable while cs high
//  databyte1  in   8        frame byte 1
//  databyte2  in   8        frame byte 2
//  re         in   1        VGA read enable (priority requester)
//  raddr      in   ADDR_W   VGA read address
//  state      out  STATE_W  game state to vga_top
//  score      out  10       score to vga_top
//  mem_addr   out  ADDR_W   shared memory address
//  mem_we     out  1        memory write strobe
//  mem_wdata  out  DATA_W   memory write data
//  busy       out  1        write pending or CLEAR running
//  overrun    out  1        sticky: frame arrived while busy (dropped)
//  bad_op     out  1        sticky: undefined opcode received
// BEHAVIOUR
//  Reset: state=0, score=0, mem_we=0, mem_wdata=0, busy=0, overrun=0,
//   bad_op=0, FSM=IDLE, sync flops=1 (idle cs). mem_addr follows mux.
//  Frame detect: cs through 2-flop synchronizer; rising edge of synced cs
//   in cycle E = frame complete; command/databytes captured into local
//   regs at E (after the synchronizer, so pins have settled).
//  Opcodes (command[7:4]); a=databyte1[ADDR_W-9:0]:databyte2 (10 bits):
//   0x0 NOP        no effect.
//   0x1 SET_STATE  state <= {databyte1,databyte2}, visible at E+1.
//   0x2 SET_SCORE  score <= min(a, SCORE_MAX), visible at E+1.
//   0x3 INC_SCORE  score <= score+1, saturates at SCORE_MAX, at E+1.
//   0x4 WR_TILE    write command[DATA_W-1:0] to address a.
//   0x5 CLEAR      write 0 to every address 0..2^ADDR_W-1, ascending.
//   others         bad_op <= 1 at E+1, no other effect.
//  FSM: IDLE -> (WR_TILE) WRITE -> IDLE; IDLE -> (CLEAR) SWEEP -> IDLE.
//   WRITE: mem_we=1 on first cycle >=E+1 with re=0; then IDLE next cycle.
//   SWEEP: counter from 0; each cycle with re=0 writes counter and
//    increments; after address 2^ADDR_W-1 is written -> IDLE (no wrap).
//   re=1 in WRITE/SWEEP: mem_we=0, counter holds; no write is lost.
//  Mux: mem_addr = re ? raddr : (SWEEP ? counter : captured a).
//   mem_we never asserted while re=1.
//  busy = 1 in WRITE/SWEEP (from E+1 until cycle after last write).
//  Frame edge while busy: frame dropped, overrun <= 1; running op
//   continues unchanged. Register ops never make busy.
//  Reset mid-op: sweep/write abandoned immediately, all outputs to reset.
// STRUCTURE
//  Package cmd_pkg: opcode enum (NOP..CLEAR), FSM state enum,
//   SCORE_W=10 constant.
//  One sub-module: sync_edge (2-flop synchronizer + rising-edge pulse).
//  Remainder (capture, decode, FSM, counter, mux) in cmd_controller.
// TESTING
//  1 SET_STATE cmd=0x10,b1=0xAB,b2=0xCD -> state=0xABCD one cycle after
//    detected edge; busy stays 0.
//  2 SET_SCORE a=0x3FF -> score=999; INC_SCORE x3 from 997 -> 998,999,999.
//  3 WR_TILE cmd=0x45,a=0x123 with re=1 for 5 cycles -> mem_we=0 while
//    re=1, then one mem_we pulse, mem_addr=0x123, mem_wdata=3'b101.
//  4 CLEAR with re toggling 50% -> exactly 1024 we pulses, addresses
//    0..1023 each once, ascending; busy falls after address 1023.
//  5 SET_STATE frame during CLEAR -> state unchanged, overrun=1, sweep
//    completes; opcode 0xF -> bad_op=1.
//  6 resetB low mid-CLEAR -> mem_we=0, busy=0, state=score=0 immediately;
//    after release a new WR_TILE completes normally.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types and constants for the SPI command controller.
package cmd_pkg;

  // Score register width; the score saturates well inside this range.
  localparam int SCORE_W = 10;

  // Opcodes carried in command[7:4].
  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_SET_STATE = 4'h1,
    OP_SET_SCORE = 4'h2,
    OP_INC_SCORE = 4'h3,
    OP_WR_TILE   = 4'h4,
    OP_CLEAR     = 4'h5
  } opcode_e;

  // Controller FSM states for memory-writing operations.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SWEEP = 2'd2
  } fsm_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse
// on its synchronized rising edge. Flops reset to the idle level so that
// leaving reset with the line idle never produces a spurious edge.
module sync_edge #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic resetB,
  input  logic d_async,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      sync1_reg <= IDLE_LEVEL;
      sync2_reg <= IDLE_LEVEL;
      prev_reg  <= IDLE_LEVEL;
    end else begin
      sync1_reg <= d_async;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/cmd_controller.sv
// Turns completed SPI frames into game register updates and tile memory
// writes. The VGA read port always owns the memory address when re is high;
// pending tile writes and CLEAR sweeps only advance on cycles with re low.
module cmd_controller
  import cmd_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 3,
  parameter int          STATE_W   = 16,
  parameter int unsigned SCORE_MAX = 999
) (
  input  logic               clk,
  input  logic               resetB,
  input  logic               cs,
  input  logic [7:0]         command,
  input  logic [7:0]         databyte1,
  input  logic [7:0]         databyte2,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               busy,
  output logic               overrun,
  output logic               bad_op
);

  localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

  logic               frame_rise;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  frame_addr;
  logic               sweep_last;

  fsm_e               fsm_reg;
  fsm_e               fsm_next;
  logic [ADDR_W-1:0]  sweep_cnt_reg;
  logic [ADDR_W-1:0]  cap_addr_reg;
  logic [DATA_W-1:0]  cap_data_reg;
  logic [STATE_W-1:0] state_reg;
  logic [SCORE_W-1:0] score_reg;
  logic               overrun_reg;
  logic               bad_op_reg;

  // Operand bits above the tile colour are not used by any opcode.
  logic unused_cmd_bits;
  assign unused_cmd_bits = &{1'b0, command[3:DATA_W]};

  // cs rising (synchronized) marks a complete frame; the frame pins have
  // been stable for the synchronizer latency by then.
  sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk     (clk),
    .resetB  (resetB),
    .d_async (cs),
    .rise    (frame_rise)
  );

  assign opcode     = command[7:4];
  assign frame_addr = {databyte1[ADDR_W-9:0], databyte2};
  assign sweep_last = (sweep_cnt_reg == {ADDR_W{1'b1}});

  assign state   = state_reg;
  assign score   = score_reg;
  assign overrun = overrun_reg;
  assign bad_op  = bad_op_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) fsm_reg <= ST_IDLE;
    else         fsm_reg <= fsm_next;
  end

  // Next-state and memory port outputs; re overrides address and blocks we.
  always_comb begin
    fsm_next  = fsm_reg;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = cap_addr_reg;
    busy      = 1'b0;
    case (fsm_reg)
      ST_IDLE: begin
        if (frame_rise) begin
          if (opcode == OP_WR_TILE)   fsm_next = ST_WRITE;
          else if (opcode == OP_CLEAR) fsm_next = ST_SWEEP;
        end
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_we    = ~re;
        mem_wdata = cap_data_reg;
        if (!re) fsm_next = ST_IDLE;
      end
      ST_SWEEP: begin
        busy     = 1'b1;
        mem_we   = ~re;
        mem_addr = sweep_cnt_reg;
        if (!re && sweep_last) fsm_next = ST_IDLE;
      end
      default: fsm_next = ST_IDLE;
    endcase
    if (re) mem_addr = raddr;
  end

  // Sweep address counter: parked at 0 outside a sweep, holds while re.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB)                 sweep_cnt_reg <= '0;
    else if (fsm_reg != ST_SWEEP) sweep_cnt_reg <= '0;
    else if (!re)                 sweep_cnt_reg <= sweep_cnt_reg + ADDR_W'(1);
  end

  // Frame decode: register ops, write capture, and sticky error flags.
  // A frame arriving while a memory op runs is dropped entirely.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      cap_addr_reg <= '0;
      cap_data_reg <= '0;
      state_reg    <= '0;
      score_reg    <= '0;
      overrun_reg  <= 1'b0;
      bad_op_reg   <= 1'b0;
    end else if (frame_rise) begin
      if (fsm_reg != ST_IDLE) begin
        overrun_reg <= 1'b1;
      end else begin
        cap_addr_reg <= frame_addr;
        cap_data_reg <= command[DATA_W-1:0];
        case (opcode)
          OP_NOP: begin
          end
          OP_SET_STATE: state_reg <= STATE_W'({databyte1, databyte2});
          OP_SET_SCORE: score_reg <= (32'(frame_addr) > SCORE_MAX) ? SCORE_CAP
                                                                   : SCORE_W'(frame_addr);
          OP_INC_SCORE: score_reg <= (score_reg >= SCORE_CAP) ? SCORE_CAP
                                                              : score_reg + SCORE_W'(1);
          OP_WR_TILE, OP_CLEAR: begin
          end
          default: bad_op_reg <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_controller.sv
// Directed self-checking bench for cmd_controller.
module tb_cmd_controller;

  logic        clk;
  logic        resetB;
  logic        cs;
  logic [7:0]  command;
  logic [7:0]  databyte1;
  logic [7:0]  databyte2;
  logic        re;
  logic [9:0]  raddr;
  logic [15:0] state;
  logic [9:0]  score;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic        busy;
  logic        overrun;
  logic        bad_op;

  int checks = 0;
  int errors = 0;

  // Write monitor state (used during sweeps)
  logic mon_en = 1'b0;
  int   we_count;
  int   order_bad;
  int   data_bad;
  int   conflict;
  int   exp_addr;

  cmd_controller dut (
    .clk       (clk),
    .resetB    (resetB),
    .cs        (cs),
    .command   (command),
    .databyte1 (databyte1),
    .databyte2 (databyte2),
    .re        (re),
    .raddr     (raddr),
    .state     (state),
    .score     (score),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .overrun   (overrun),
    .bad_op    (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle while enabled.
  always @(negedge clk) begin
    if (mon_en && mem_we) begin
      if (mem_addr !== 10'(exp_addr)) order_bad++;
      if (mem_wdata !== 3'b000) data_bad++;
      if (re) conflict++;
      exp_addr++;
      we_count++;
    end
  end

  task automatic mon_start();
    we_count = 0; order_bad = 0; data_bad = 0; conflict = 0; exp_addr = 0;
    mon_en = 1'b1;
  endtask

  // Present a frame, pulse cs low for two cycles, return at cs rising.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk);
    command = c; databyte1 = b1; databyte2 = b2; cs = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
  endtask

  task automatic test_reset();
    resetB = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 16'h0)   begin errors++; $display("FAIL reset_state: got %h expected %h", state, 16'h0); end
    checks++; if (score !== 10'd0)   begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_wdata !== 3'b0) begin errors++; $display("FAIL reset_wdata: got %b expected 000", mem_wdata); end
    checks++; if (mem_addr !== 10'h0) begin errors++; $display("FAIL reset_addr: got %h expected 000", mem_addr); end
    checks++; if ({busy, overrun, bad_op} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, overrun, bad_op}); end
    resetB = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_set_state();
    send_frame(8'h10, 8'hAB, 8'hCD);
    repeat (2) @(negedge clk);
    checks++; if (state !== 16'h0) begin errors++; $display("FAIL set_state_early: got %h expected 0000", state); end
    @(negedge clk);
    checks++; if (state !== 16'hABCD) begin errors++; $display("FAIL set_state: got %h expected abcd", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL set_state_busy: got %b expected 0", busy); end
    $display("test_set_state: state=%h", state);
  endtask

  task automatic test_score();
    int exp_tab [3] = '{998, 999, 999};
    send_frame(8'h20, 8'h03, 8'hFF);
    repeat (3) @(negedge clk);
    checks++; if (score !== 10'd999) begin errors++; $display("FAIL set_score_sat: got %0d expected 999", score); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL set_score_busy: got %b expected 0", busy); end
    send_frame(8'h20, 8'h03, 8'hE5);
    repeat (3) @(negedge clk);
    checks++; if (score !== 10'd997) begin errors++; $display("FAIL set_score_997: got %0d expected 997", score); end
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h30, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      checks++; if (score !== 10'(exp_tab[i])) begin errors++; $display("FAIL inc_score_%0d: got %0d expected %0d", i, score, exp_tab[i]); end
      $display("test_score: inc %0d score=%0d", i, score);
    end
  endtask

  task automatic test_wr_tile();
    @(negedge clk);
    re = 1'b1; raddr = 10'h055;
    send_frame(8'h45, 8'h01, 8'h23);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_tile_blocked_%0d: we got %b expected 0", i, mem_we); end
      checks++; if (mem_addr !== 10'h055) begin errors++; $display("FAIL wr_tile_raddr_%0d: addr got %h expected 055", i, mem_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_tile_busy_%0d: got %b expected 1", i, busy); end
      @(negedge clk);
    end
    re = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_tile_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 10'h123) begin errors++; $display("FAIL wr_tile_addr: got %h expected 123", mem_addr); end
    checks++; if (mem_wdata !== 3'b101) begin errors++; $display("FAIL wr_tile_data: got %b expected 101", mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_we, busy} !== 2'b00) begin errors++; $display("FAIL wr_tile_done: we,busy got %b expected 00", {mem_we, busy}); end
    $display("test_wr_tile: write to 123 data 101 observed");
  endtask

  task automatic test_clear();
    logic seen, done, prev_we;
    logic [9:0] prev_addr;
    seen = 1'b0; done = 1'b0; prev_we = 1'b0; prev_addr = '0;
    mon_start();
    send_frame(8'h50, 8'h00, 8'h00);
    for (int i = 0; i < 4000 && !done; i++) begin
      @(posedge clk);
      #2 re = i[0];
      raddr = 10'($urandom);
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
      if (!done) begin prev_we = mem_we; prev_addr = mem_addr; end
    end
    re = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clear_timeout: busy fell got %b expected 1", done); end
    checks++; if (we_count != 1024) begin errors++; $display("FAIL clear_count: got %0d expected 1024", we_count); end
    checks++; if (order_bad != 0) begin errors++; $display("FAIL clear_order: out-of-order writes got %0d expected 0", order_bad); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL clear_data: nonzero writes got %0d expected 0", data_bad); end
    checks++; if (conflict != 0) begin errors++; $display("FAIL clear_re_conflict: got %0d expected 0", conflict); end
    checks++; if ({prev_we, prev_addr} !== {1'b1, 10'h3FF}) begin errors++; $display("FAIL clear_last: we,addr before busy fell got %b,%h expected 1,3ff", prev_we, prev_addr); end
    $display("test_clear: %0d writes", we_count);
  endtask

  task automatic test_overrun_badop();
    logic done;
    done = 1'b0;
    re = 1'b0;
    mon_start();
    send_frame(8'h50, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
    send_frame(8'h10, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    checks++; if (state !== 16'hABCD) begin errors++; $display("FAIL overrun_state: got %h expected abcd", state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: got %b expected 1", busy); end
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    mon_en = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL overrun_sweep_timeout: got %b expected 1", done); end
    checks++; if (we_count != 1024 || order_bad != 0) begin errors++; $display("FAIL overrun_sweep: writes %0d bad %0d expected 1024 0", we_count, order_bad); end
    checks++; if (bad_op !== 1'b0) begin errors++; $display("FAIL bad_op_pre: got %b expected 0", bad_op); end
    send_frame(8'hF0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checks++; if (bad_op !== 1'b1) begin errors++; $display("FAIL bad_op_set: got %b expected 1", bad_op); end
    checks++; if ({state, busy} !== {16'hABCD, 1'b0}) begin errors++; $display("FAIL bad_op_side: state,busy got %h,%b expected abcd,0", state, busy); end
    $display("test_overrun_badop: overrun=%b bad_op=%b", overrun, bad_op);
  endtask

  task automatic test_reset_mid_clear();
    send_frame(8'h50, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b expected 1", busy); end
    resetB = 1'b0;
    #1;
    checks++; if ({mem_we, busy} !== 2'b00) begin errors++; $display("FAIL midreset_we_busy: got %b expected 00", {mem_we, busy}); end
    checks++; if (state !== 16'h0 || score !== 10'd0) begin errors++; $display("FAIL midreset_regs: state,score got %h,%0d expected 0000,0", state, score); end
    checks++; if ({overrun, bad_op} !== 2'b00) begin errors++; $display("FAIL midreset_flags: got %b expected 00", {overrun, bad_op}); end
    repeat (2) @(negedge clk);
    resetB = 1'b1;
    send_frame(8'h42, 8'h03, 8'hC0);
    repeat (2) @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL post_reset_early_we: got %b expected 0", mem_we); end
    @(negedge clk);
    checks++; if ({mem_we, busy} !== 2'b11) begin errors++; $display("FAIL post_reset_we: we,busy got %b expected 11", {mem_we, busy}); end
    checks++; if (mem_addr !== 10'h3C0 || mem_wdata !== 3'b010) begin errors++; $display("FAIL post_reset_write: addr,data got %h,%b expected 3c0,010", mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_we, busy} !== 2'b00) begin errors++; $display("FAIL post_reset_done: we,busy got %b expected 00", {mem_we, busy}); end
    $display("test_reset_mid_clear done");
  endtask

  initial begin
    resetB = 1'b0; cs = 1'b1; command = 8'h00; databyte1 = 8'h00; databyte2 = 8'h00;
    re = 1'b0; raddr = 10'h000;
    test_reset();
    test_set_state();
    test_score();
    test_wr_tile();
    test_clear();
    test_overrun_badop();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
